// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin output multiplexer.
package rr_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FORCE = 1'b1;

  // Next channel index after idx, wrapping at n.
  function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant selection for rr_mux_n: round-robin from ptr+1 or forced select.
// RR_MUX_FIXED_PRI_EN turns round-robin mode into lowest-index-wins priority.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  input  logic [SEL_W-1:0] select,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_idx
);

`ifndef RR_MUX_FIXED_PRI_EN
  int unsigned      cand;
  logic [SEL_W-1:0] cand_idx;
`endif

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
`ifndef RR_MUX_FIXED_PRI_EN
    cand        = 32'(ptr);
    cand_idx    = ptr;
`endif
    if (mode == MODE_FORCE) begin
      // Out-of-range select matches no channel, so no grant.
      for (int unsigned i = 0; i < N; i++) begin
        if (SEL_W'(i) == select && req[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end else begin
`ifdef RR_MUX_FIXED_PRI_EN
      for (int unsigned i = 0; i < N; i++) begin
        if (!grant_valid && req[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
`else
      for (int unsigned k = 0; k < N; k++) begin
        cand     = rr_next_idx(cand, N);
        cand_idx = SEL_W'(cand);
        if (!grant_valid && req[cand_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = cand_idx;
        end
      end
`endif
    end
  end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel registered multiplexer with valid/ready handshake and round-robin
// or forced channel selection. Build option: RR_MUX_FIXED_PRI_EN (in rr_arbiter).
module rr_mux_n
  import rr_mux_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] select,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [SEL_W-1:0] ptr;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic             load_c;
  logic             xfer_c;
  logic [W-1:0]     grant_data_c;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req         (in_valid),
    .ptr         (ptr),
    .mode        (mode),
    .select      (select),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // No acceptance while reset is held, so nothing is granted into a cleared register.
  assign load_c = (!out_valid || out_ready) && !rst;
  assign xfer_c = load_c && grant_valid;

  always_comb begin
    in_ready     = '0;
    grant_data_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (SEL_W'(i) == grant_idx) begin
        in_ready[i]  = xfer_c;
        grant_data_c = in_data[i*W +: W];
      end
    end
  end

  // Output stage and fairness pointer; ptr follows forced transfers too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SEL_W'(N - 1);
    end else if (xfer_c) begin
      out_valid <= 1'b1;
      out_data  <= grant_data_c;
      out_sel   <= grant_idx;
      ptr       <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed self-checking bench for rr_mux_n (N=4, W=8, default build).
module tb_rr_mux_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  select;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  rr_mux_n #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .select    (select),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  localparam logic [31:0] DATA_A = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

  initial begin
    rst       = 1'b1;
    in_data   = DATA_A;
    in_valid  = 4'b1111;
    mode      = 1'b0;
    select    = 2'd0;
    out_ready = 1'b1;

    // Reset holds everything idle even with all channels valid.
    tick();
    tick();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data",  32'(out_data),  32'd0);
    check_eq("rst_sel",   32'(out_sel),   32'd0);
    check_eq("rst_ready", 32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    check_eq("first_grant", 32'(in_ready), 32'b0001);

    // Round-robin fairness over all four channels, one word per cycle.
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("rr_valid", 32'(out_valid), 32'd1);
      check_eq("rr_sel",   32'(out_sel),   32'(k % 4));
      check_eq("rr_data",  32'(out_data),  32'hA0 + 32'(k % 4));
      check_eq("rr_ready", 32'(in_ready),  32'(1 << ((k + 1) % 4)));
    end

    // Sparse wrap: channels 0 and 3 alternate, 1 and 2 never see ready.
    do_reset();
    in_valid = 4'b1001;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq("sparse_ready12", 32'(in_ready & 4'b0110), 32'd0);
      tick();
      check_eq("sparse_sel", 32'(out_sel), (k % 2 == 0) ? 32'd0 : 32'd3);
    end

    // Forced select of channel 2.
    mode     = 1'b1;
    select   = 2'b10;
    in_valid = 4'b1111;
    in_data  = {8'hA3, 8'h5C, 8'hA1, 8'hA0};
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("force_ready", 32'(in_ready), 32'b0100);
      tick();
      check_eq("force_data", 32'(out_data), 32'h5C);
      check_eq("force_sel",  32'(out_sel),  32'd2);
    end
    // Forced channel not valid: nothing moves, register drains.
    select   = 2'b01;
    in_valid = 4'b1101;
    #1;
    check_eq("force_idle_ready", 32'(in_ready), 32'd0);
    tick();
    check_eq("force_idle_valid", 32'(out_valid), 32'd0);
    check_eq("force_idle_hold",  32'(out_data),  32'h5C);
    // Back to round-robin continues after the last forced channel (2).
    mode     = 1'b0;
    in_valid = 4'b1111;
    #1;
    check_eq("resume_rr_ready", 32'(in_ready), 32'b1000);

    // Backpressure after the first load.
    in_data = DATA_A;
    do_reset();
    tick();
    check_eq("bp_first", 32'(out_data), 32'hA0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("bp_ready", 32'(in_ready), 32'd0);
      tick();
      check_eq("bp_hold",  32'(out_data),  32'hA0);
      check_eq("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(in_ready), 32'b0010);
    tick();
    check_eq("bp_next_data",  32'(out_data),  32'hA1);
    check_eq("bp_next_valid", 32'(out_valid), 32'd1);

    // Mid-stream asynchronous reset.
    tick();
    check_eq("mid_pre_data", 32'(out_data), 32'hA2);
    rst = 1'b1;
    #1;
    check_eq("mid_valid", 32'(out_valid), 32'd0);
    check_eq("mid_data",  32'(out_data),  32'd0);
    check_eq("mid_sel",   32'(out_sel),   32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("mid_restart_ready", 32'(in_ready), 32'b0001);
    tick();
    check_eq("mid_restart_sel",  32'(out_sel),  32'd0);
    check_eq("mid_restart_data", 32'(out_data), 32'hA0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
